ex_mem_reg: RTL

- EX/MEM pipeline register directly downstream of the execute ALU.
- Captures the ALU result, branch flag and memory-access control for one instruction, and presents them to the MEM stage with a valid/ready handshake.
- For multi-cycle mul/div ops, waits for the ALU's output valid and returns `ready_flag` to release the mul/div unit.
- Generates the EX-stage advance signal (`ex_ready`) back to ID/EX.

---
 rtl/ex_mem_reg_if.sv | 70 +++++++
 rtl/ex_mem_reg.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg_if.sv
// EX/MEM pipeline register bus: EX-side inputs, MEM-side handshake and the
// registered op. The optional forwarding outputs exist only when
// EX_MEM_FWD_EN is defined.
// master: upstream/downstream environment (drives EX fields, mem_ready)
// slave : the EX/MEM register itself
interface ex_mem_reg_if #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
);
  logic            flush_flag;
  logic            ex_valid;
  logic            ex_mc;
  logic            alu_o_valid;
  logic [XLEN-1:0] alu_res;
  logic            alu_branch_flag;
  logic [XLEN-1:0] ex_pc;
  logic [RD_W-1:0] ex_rd;
  logic            ex_rd_wen;
  logic            ex_load;
  logic            ex_store;
  logic [1:0]      ex_size;
  logic [XLEN-1:0] ex_store_data;
  logic            mem_ready;

  logic            ex_ready;
  logic            ready_flag;
  logic            mc_busy;
  logic            EX_MEM_reg_valid;
  logic [XLEN-1:0] EX_MEM_reg_res;
  logic            EX_MEM_reg_branch;
  logic [XLEN-1:0] EX_MEM_reg_pc;
  logic [RD_W-1:0] EX_MEM_reg_rd;
  logic            EX_MEM_reg_rd_wen;
  logic            EX_MEM_reg_load;
  logic            EX_MEM_reg_store;
  logic [1:0]      EX_MEM_reg_size;
  logic [XLEN-1:0] EX_MEM_reg_store_data;

`ifdef EX_MEM_FWD_EN
  logic            fwd_valid;
  logic [RD_W-1:0] fwd_rd;
  logic [XLEN-1:0] fwd_data;
`endif

  modport master (
`ifdef EX_MEM_FWD_EN
    input  fwd_valid, fwd_rd, fwd_data,
`endif
    output flush_flag, ex_valid, ex_mc, alu_o_valid, alu_res, alu_branch_flag,
           ex_pc, ex_rd, ex_rd_wen, ex_load, ex_store, ex_size, ex_store_data,
           mem_ready,
    input  ex_ready, ready_flag, mc_busy,
           EX_MEM_reg_valid, EX_MEM_reg_res, EX_MEM_reg_branch, EX_MEM_reg_pc,
           EX_MEM_reg_rd, EX_MEM_reg_rd_wen, EX_MEM_reg_load, EX_MEM_reg_store,
           EX_MEM_reg_size, EX_MEM_reg_store_data
  );

  modport slave (
`ifdef EX_MEM_FWD_EN
    output fwd_valid, fwd_rd, fwd_data,
`endif
    input  flush_flag, ex_valid, ex_mc, alu_o_valid, alu_res, alu_branch_flag,
           ex_pc, ex_rd, ex_rd_wen, ex_load, ex_store, ex_size, ex_store_data,
           mem_ready,
    output ex_ready, ready_flag, mc_busy,
           EX_MEM_reg_valid, EX_MEM_reg_res, EX_MEM_reg_branch, EX_MEM_reg_pc,
           EX_MEM_reg_rd, EX_MEM_reg_rd_wen, EX_MEM_reg_load, EX_MEM_reg_store,
           EX_MEM_reg_size, EX_MEM_reg_store_data
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register. Captures one EX op (ALU result, branch flag,
// memory-access control) and hands it to MEM with valid/ready. Multi-cycle
// mul/div ops are held in EX until the ALU result is valid and the slot is
// free; ready_flag releases the mul/div unit.
// Optional: EX_MEM_FWD_EN adds fwd_valid/fwd_rd/fwd_data forwarding outputs.
//
// state | meaning
// IDLE  | no multi-cycle op outstanding
// WAIT  | mul/div issued, waiting for alu_o_valid
// DONE  | mul/div result valid, waiting for a free output slot
module ex_mem_reg #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_mem_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            slot_free;
  logic            res_ok;
  logic            accept;

  logic            valid_q;
  logic [XLEN-1:0] res_q;
  logic            branch_q;
  logic [XLEN-1:0] pc_q;
  logic [RD_W-1:0] rd_q;
  logic            rd_wen_q;
  logic            load_q;
  logic            store_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] store_data_q;

  // Acceptance: op present, result available, slot empty or draining, no flush.
  // Gated by rst_n so nothing is handed off while reset is asserted.
  always_comb begin
    slot_free = !valid_q | bus.mem_ready;
    res_ok    = !bus.ex_mc | bus.alu_o_valid;
    accept    = rst_n & bus.ex_valid & res_ok & slot_free & !bus.flush_flag;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state; flush always returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (bus.flush_flag) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.ex_valid & bus.ex_mc) begin
            if (!bus.alu_o_valid) begin
              state_nxt = ST_WAIT;
            end else if (!slot_free) begin
              state_nxt = ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (bus.alu_o_valid) begin
            state_nxt = slot_free ? ST_IDLE : ST_DONE;
          end
        end
        ST_DONE: begin
          if (slot_free) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM / handshake outputs; all held low while reset is asserted.
  always_comb begin
    bus.ex_ready   = rst_n & (accept | (!bus.ex_valid & !bus.flush_flag));
    bus.ready_flag = accept & bus.ex_mc;
    bus.mc_busy    = rst_n & (state != ST_IDLE);
  end

  // Pipeline register: flush > accept > drain > hold. Fields are left as-is
  // when valid drops; only valid carries meaning then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      res_q        <= '0;
      branch_q     <= 1'b0;
      pc_q         <= '0;
      rd_q         <= '0;
      rd_wen_q     <= 1'b0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
      size_q       <= 2'd0;
      store_data_q <= '0;
    end else if (bus.flush_flag) begin
      valid_q      <= 1'b0;
    end else if (accept) begin
      valid_q      <= 1'b1;
      res_q        <= bus.alu_res;
      branch_q     <= bus.alu_branch_flag;
      pc_q         <= bus.ex_pc;
      rd_q         <= bus.ex_rd;
      rd_wen_q     <= bus.ex_rd_wen;
      load_q       <= bus.ex_load;
      store_q      <= bus.ex_store;
      size_q       <= bus.ex_size;
      store_data_q <= bus.ex_store_data;
    end else if (bus.mem_ready) begin
      valid_q      <= 1'b0;
    end
  end

  assign bus.EX_MEM_reg_valid      = valid_q;
  assign bus.EX_MEM_reg_res        = res_q;
  assign bus.EX_MEM_reg_branch     = branch_q;
  assign bus.EX_MEM_reg_pc         = pc_q;
  assign bus.EX_MEM_reg_rd         = rd_q;
  assign bus.EX_MEM_reg_rd_wen     = rd_wen_q;
  assign bus.EX_MEM_reg_load       = load_q;
  assign bus.EX_MEM_reg_store      = store_q;
  assign bus.EX_MEM_reg_size       = size_q;
  assign bus.EX_MEM_reg_store_data = store_data_q;

`ifdef EX_MEM_FWD_EN
  // Forward only ALU results that will write a real register; load data is
  // not available until MEM, and x0 never forwards.
  always_comb begin
    bus.fwd_valid = valid_q & rd_wen_q & !load_q & (rd_q != '0);
    bus.fwd_rd    = rd_q;
    bus.fwd_data  = res_q;
  end
`endif

endmodule
